// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: radix-2 shift-add multiply and restoring
// divide, one iteration per clock, fixed latency for every operand pair.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} stateT;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  stateT                state, stateNext;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     addend;
  logic                 negRes;
  logic                 divZero;
  logic                 divOvf;

  logic                 startMult, startDiv, startAny, lastStep;
  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulFinal;
  logic [WIDTH:0]       divShift;
  logic                 divGe;
  logic [WIDTH-1:0]     divDiff;
  logic [WIDTH-1:0]     quoFinal;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] negIfWide(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  // Product fits in WIDTH signed bits when the top WIDTH+1 bits are all equal.
  function automatic logic fitsSigned(input logic [2*WIDTH-1:0] p);
    return (&p[2*WIDTH-1:WIDTH-1]) | ~(|p[2*WIDTH-1:WIDTH-1]);
  endfunction

  assign startMult = ctrl_MULT & ~ctrl_DIV;
  assign startDiv  = ctrl_DIV & ~ctrl_MULT;
  assign startAny  = startMult | startDiv;
  assign lastStep  = (cnt == CNT_W'(WIDTH));

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, addend} : '0);
  assign mulFinal = negIfWide(acc, negRes);

  // Divide: acc holds {remainder, dividend bits shifting into quotient}.
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divGe    = (divShift >= {1'b0, addend});
  assign divDiff  = WIDTH'(divShift - {1'b0, addend});
  assign quoFinal = negIf(acc[WIDTH-1:0], negRes);

  assign data_resultRDY = (state == DONE);

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) state <= IDLE;
    else             state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = IDLE;
      MULT: if (lastStep) stateNext = DONE;
      DIV:  if (lastStep) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (startMult)     stateNext = MULT;
    else if (startDiv) stateNext = DIV;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      cnt            <= '0;
      acc            <= '0;
      addend         <= '0;
      negRes         <= 1'b0;
      divZero        <= 1'b0;
      divOvf         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (startAny) begin
      cnt     <= '0;
      negRes  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      divZero <= (data_operandB == '0);
      divOvf  <= (data_operandA == MIN_VAL) && (data_operandB == '1);
      addend  <= startMult ? magnitude(data_operandA) : magnitude(data_operandB);
      acc     <= {{WIDTH{1'b0}}, startMult ? magnitude(data_operandB) : magnitude(data_operandA)};
    end else begin
      case (state)
        MULT: begin
          if (!lastStep) begin
            acc <= {mulSum, acc[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
          end else begin
            data_result    <= mulFinal[WIDTH-1:0];
            data_exception <= ~fitsSigned(mulFinal);
          end
        end
        DIV: begin
          if (!lastStep) begin
            if (divGe) acc <= {divDiff, acc[WIDTH-2:0], 1'b1};
            else       acc <= {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
          end else begin
            data_result    <= divZero ? '0 : quoFinal;
            data_exception <= divZero | divOvf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, signed results, exceptions,
// abort/ignored starts and asynchronous reset.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        mulReq = 1'b0;
  logic        divReq = 1'b0;
  logic [31:0] result;
  logic        exception;
  logic        rdy;

  int checks = 0;
  int failures = 0;

  multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .ctrl_reset     (rstN),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .ctrl_MULT      (mulReq),
    .ctrl_DIV       (divReq),
    .data_result    (result),
    .data_exception (exception),
    .data_resultRDY (rdy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle start pulse; returns 1 time unit after the capture edge.
  task automatic startPulse(input logic isMult, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opA = a; opB = b; mulReq = isMult; divReq = !isMult;
    @(posedge clock); #1;
    mulReq = 1'b0; divReq = 1'b0;
    opA = 32'hDEADBEEF; opB = 32'h0BADF00D;
  endtask

  task automatic waitRdy(input string tag, input logic [31:0] expRes, input logic expExc);
    int edges = 0;
    logic [31:0] held;
    while (rdy !== 1'b1 && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd33);
    check({tag, "_result"}, {32'd0, result}, {32'd0, expRes});
    check({tag, "_exc"}, {63'd0, exception}, {63'd0, expExc});
    held = result;
    @(posedge clock); #1;
    check({tag, "_rdy_drop"}, {63'd0, rdy}, 64'd0);
    repeat (3) begin @(posedge clock); #1; end
    check({tag, "_hold"}, {32'd0, result}, {32'd0, held});
  endtask

  task automatic watchNoRdy(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (rdy === 1'b1) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #12;
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_exc", {63'd0, exception}, 64'd0);
    check("reset_rdy", {63'd0, rdy}, 64'd0);
    @(negedge clock); rstN = 1'b1;

    startPulse(1'b1, 32'd7, 32'hFFFFFFFA);
    waitRdy("mul_7_m6", 32'hFFFFFFD6, 1'b0);

    startPulse(1'b1, 32'h00010000, 32'h00010000);
    waitRdy("mul_ovf", 32'h00000000, 1'b1);

    startPulse(1'b1, 32'h80000000, 32'd1);
    waitRdy("mul_min", 32'h80000000, 1'b0);

    startPulse(1'b0, 32'hFFFFFFF9, 32'd2);
    waitRdy("div_m7_2", 32'hFFFFFFFD, 1'b0);

    startPulse(1'b0, 32'd100, 32'hFFFFFFF6);
    waitRdy("div_100_m10", 32'hFFFFFFF6, 1'b0);

    startPulse(1'b0, 32'd100, 32'd0);
    waitRdy("div_zero", 32'h00000000, 1'b1);

    startPulse(1'b0, 32'h80000000, 32'hFFFFFFFF);
    waitRdy("div_ovf", 32'h80000000, 1'b1);

    // Restart a multiply with a divide partway through.
    startPulse(1'b1, 32'd3, 32'd4);
    watchNoRdy("abort_pre", 9);
    startPulse(1'b0, 32'd20, 32'd5);
    waitRdy("abort_div", 32'd4, 1'b0);
    watchNoRdy("abort_single_rdy", 40);

    @(negedge clock);
    opA = 32'd9; opB = 32'd9; mulReq = 1'b1; divReq = 1'b1;
    @(posedge clock); #1;
    mulReq = 1'b0; divReq = 1'b0;
    watchNoRdy("both_high_no_rdy", 40);
    check("both_high_result", {32'd0, result}, 64'd4);

    // Reset asserted between clock edges during a divide.
    startPulse(1'b0, 32'd1000, 32'd3);
    repeat (15) @(posedge clock);
    #3 rstN = 1'b0;
    #1;
    check("async_rst_result", {32'd0, result}, 64'd0);
    check("async_rst_exc", {63'd0, exception}, 64'd0);
    check("async_rst_rdy", {63'd0, rdy}, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock); rstN = 1'b1;
    watchNoRdy("post_rst_no_rdy", 40);

    startPulse(1'b1, 32'd2, 32'd3);
    waitRdy("mul_2_3", 32'd6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
